// File: rtl/sr_cmd_driver.sv
// ---------------------------------------------------------------------------
// SrCmdDriver -- upstream command driver for the SR latch.
//
// Two raw, bouncy push buttons are synchronised, debounced and turned into
// clean, registered, fixed-length set/reset pulses. The s and r outputs are
// never asserted together. Requests that arrive at the same moment are
// rejected and reported on a one-cycle conflict pulse.
//
// Parameters:
//   DEB_CYCLES : consecutive differing synchronised samples needed before
//                the debounced level flips (2 .. 2**CNT_W-1)
//   CNT_W      : width of each debounce counter
//   PULSE_LEN  : cycles that s or r stays high per accepted command (1..15)
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous, active-high reset
//   btn_s    in   raw set button, asynchronous to clk
//   btn_r    in   raw reset button, asynchronous to clk
//   s        out  registered set pulse to the latch
//   r        out  registered reset pulse to the latch
//   busy     out  high while a pulse or the guard gap is in progress
//   conflict out  one-cycle pulse when simultaneous set/reset is rejected
// ---------------------------------------------------------------------------
module sr_cmd_driver #(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 3,
    parameter int PULSE_LEN  = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_s,
    input  logic btn_r,
    output logic s,
    output logic r,
    output logic busy,
    output logic conflict
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE_S = 2'd1,
        DRIVE_R = 2'd2,
        GAP     = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEB_CYCLES - 1);
    localparam logic [3:0]       PULSE_LAST = 4'(PULSE_LEN - 1);

    // Channel index 0 is the set button and index 1 is the reset button.
    logic [1:0]       r_sync1;
    logic [1:0]       r_sync2;
    logic [1:0]       r_deb;
    logic [1:0]       r_debPrev;
    logic [CNT_W-1:0] r_cnt [2];
    logic [1:0]       r_pend;

    state_t           r_state;
    logic [3:0]       r_pcnt;
    logic             r_s;
    logic             r_r;
    logic             r_busy;
    logic             r_conflict;

    logic [1:0]       w_rise;
    logic             w_reqS;
    logic             w_reqR;
    state_t           w_nextState;
    logic [3:0]       w_nextPcnt;
    logic             w_conflict;
    logic [1:0]       w_consume;

    // Two-flop synchroniser and debouncer per channel. Any sample that
    // agrees with the debounced level restarts the count, so only a run of
    // DEB_CYCLES consecutive differing samples flips the level. The counter
    // clears when the level flips and saturates rather than wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_deb     <= '0;
            r_debPrev <= '0;
            r_cnt[0]  <= '0;
            r_cnt[1]  <= '0;
        end else begin
            r_sync1   <= {btn_r, btn_s};
            r_sync2   <= r_sync1;
            r_debPrev <= r_deb;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == DEB_LAST) begin
                    r_deb[i] <= ~r_deb[i];
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] != '1) begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Only a rising debounced level is a command; releasing a button does
    // nothing. In IDLE a fresh edge and a held-over pending request count
    // the same.
    assign w_rise = r_deb & ~r_debPrev;
    assign w_reqS = w_rise[0] | r_pend[0];
    assign w_reqR = w_rise[1] | r_pend[1];

    // Pending flags remember one command per channel that arrives while a
    // pulse or gap is running. Extra presses while a flag is already set are
    // dropped. Flags are only consumed from IDLE, so set and clear never
    // coincide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if ((r_state != IDLE) && w_rise[i]) begin
                    r_pend[i] <= 1'b1;
                end else if (w_consume[i]) begin
                    r_pend[i] <= 1'b0;
                end
            end
        end
    end

    // Next-state logic. Simultaneous requests in IDLE are both thrown away
    // and flagged. A drive state holds for PULSE_LEN cycles using the pulse
    // counter, and GAP forces one quiet cycle before the next command.
    always_comb begin
        w_nextState = r_state;
        w_nextPcnt  = r_pcnt;
        w_conflict  = 1'b0;
        w_consume   = 2'b00;
        case (r_state)
            IDLE: begin
                w_nextPcnt = '0;
                if (w_reqS && w_reqR) begin
                    w_conflict = 1'b1;
                    w_consume  = 2'b11;
                end else if (w_reqS) begin
                    w_nextState = DRIVE_S;
                    w_consume   = 2'b01;
                end else if (w_reqR) begin
                    w_nextState = DRIVE_R;
                    w_consume   = 2'b10;
                end
            end
            DRIVE_S, DRIVE_R: begin
                if (r_pcnt == PULSE_LAST) begin
                    w_nextState = GAP;
                    w_nextPcnt  = '0;
                end else begin
                    w_nextPcnt = r_pcnt + 4'd1;
                end
            end
            GAP: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
                w_nextPcnt  = '0;
            end
        endcase
    end

    // State register. The outputs are decoded from the next state so that
    // they are true flops aligned with the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_pcnt     <= '0;
            r_s        <= 1'b0;
            r_r        <= 1'b0;
            r_busy     <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_pcnt     <= w_nextPcnt;
            r_s        <= (w_nextState == DRIVE_S);
            r_r        <= (w_nextState == DRIVE_R);
            r_busy     <= (w_nextState != IDLE);
            r_conflict <= w_conflict;
        end
    end

    assign s        = r_s;
    assign r        = r_r;
    assign busy     = r_busy;
    assign conflict = r_conflict;

endmodule

// File: tb/tb_sr_cmd_driver.sv
// ---------------------------------------------------------------------------
// TbSrCmdDriver -- directed testbench for sr_cmd_driver.
//
// Instance dutA uses the default parameters and instance dutB uses
// DEB_CYCLES=2, PULSE_LEN=1. Both share clock and reset. Edge numbers in
// the expected values count from the first clock edge that samples the
// newly driven button level.
// ---------------------------------------------------------------------------
module tb_sr_cmd_driver;

    logic clk = 1'b0;
    logic reset;
    logic btnSA, btnRA, btnSB, btnRB;
    logic sA, rA, busyA, conflictA;
    logic sB, rB, busyB, conflictB;

    int errors = 0;
    int checks = 0;

    sr_cmd_driver dutA (
        .clk      (clk),
        .reset    (reset),
        .btn_s    (btnSA),
        .btn_r    (btnRA),
        .s        (sA),
        .r        (rA),
        .busy     (busyA),
        .conflict (conflictA)
    );

    sr_cmd_driver #(.DEB_CYCLES(2), .CNT_W(3), .PULSE_LEN(1)) dutB (
        .clk      (clk),
        .reset    (reset),
        .btn_s    (btnSB),
        .btn_r    (btnRB),
        .s        (sB),
        .r        (rB),
        .busy     (busyB),
        .conflict (conflictB)
    );

    always #5 clk = ~clk;

    // Drive all four buttons, then advance one rising edge and settle.
    task automatic applyStimulus(input logic sa, input logic ra,
                                 input logic sb, input logic rb);
        btnSA = sa;
        btnRA = ra;
        btnSB = sb;
        btnRB = rb;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic observed,
                               input logic expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0b expected=%0b", tag, observed, expected);
        end
    endtask

    initial begin
        reset = 1'b1;
        btnSA = 1'b0;
        btnRA = 1'b0;
        btnSB = 1'b0;
        btnRB = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_s", sA, 1'b0);
        checkOutput("rst_r", rA, 1'b0);
        checkOutput("rst_busy", busyA, 1'b0);
        checkOutput("rst_conflict", conflictA, 1'b0);
        reset = 1'b0;
        repeat (3) applyStimulus(0, 0, 0, 0);

        $display("[TB] clean press on btn_s");
        for (int e = 1; e <= 12; e++) begin
            applyStimulus(1, 0, 0, 0);
            checkOutput($sformatf("clean_s_e%0d", e), sA, (e == 7 || e == 8));
            checkOutput($sformatf("clean_r_e%0d", e), rA, 1'b0);
            checkOutput($sformatf("clean_busy_e%0d", e), busyA, (e >= 7 && e <= 9));
        end
        for (int e = 1; e <= 12; e++) begin
            applyStimulus(0, 0, 0, 0);
            checkOutput($sformatf("release_s_e%0d", e), sA, 1'b0);
            checkOutput($sformatf("release_busy_e%0d", e), busyA, 1'b0);
        end

        $display("[TB] bouncing btn_r");
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 1, 0, 0);
            checkOutput($sformatf("bounce_r_k%0d_a", k), rA, 1'b0);
            applyStimulus(0, 1, 0, 0);
            checkOutput($sformatf("bounce_r_k%0d_b", k), rA, 1'b0);
            applyStimulus(0, 0, 0, 0);
            checkOutput($sformatf("bounce_r_k%0d_c", k), rA, 1'b0);
            checkOutput($sformatf("bounce_busy_k%0d", k), busyA, 1'b0);
        end
        for (int e = 1; e <= 12; e++) begin
            applyStimulus(0, 1, 0, 0);
            checkOutput($sformatf("bounce_hold_r_e%0d", e), rA, (e == 7 || e == 8));
            checkOutput($sformatf("bounce_hold_s_e%0d", e), sA, 1'b0);
        end
        repeat (10) applyStimulus(0, 0, 0, 0);

        $display("[TB] simultaneous press");
        for (int e = 1; e <= 10; e++) begin
            applyStimulus(1, 1, 0, 0);
            checkOutput($sformatf("conf_conflict_e%0d", e), conflictA, (e == 7));
            checkOutput($sformatf("conf_s_e%0d", e), sA, 1'b0);
            checkOutput($sformatf("conf_r_e%0d", e), rA, 1'b0);
            checkOutput($sformatf("conf_busy_e%0d", e), busyA, 1'b0);
        end
        repeat (10) applyStimulus(0, 0, 0, 0);

        $display("[TB] queued command");
        for (int e = 1; e <= 16; e++) begin
            applyStimulus(1, (e >= 2), 0, 0);
            checkOutput($sformatf("queue_s_e%0d", e), sA, (e == 7 || e == 8));
            checkOutput($sformatf("queue_r_e%0d", e), rA, (e == 11 || e == 12));
            checkOutput($sformatf("queue_busy_e%0d", e), busyA,
                        ((e >= 7 && e <= 9) || (e >= 11 && e <= 13)));
        end
        repeat (10) applyStimulus(0, 0, 0, 0);

        $display("[TB] reset during DRIVE_S");
        for (int e = 1; e <= 7; e++) begin
            applyStimulus(1, 0, 0, 0);
        end
        checkOutput("midrst_pre_s", sA, 1'b1);
        #2;
        reset = 1'b1;
        btnSA = 1'b0;
        #1;
        checkOutput("midrst_s", sA, 1'b0);
        checkOutput("midrst_r", rA, 1'b0);
        checkOutput("midrst_busy", busyA, 1'b0);
        checkOutput("midrst_conflict", conflictA, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            applyStimulus(0, 0, 0, 0);
            checkOutput($sformatf("postrst_s_e%0d", e), sA, 1'b0);
            checkOutput($sformatf("postrst_busy_e%0d", e), busyA, 1'b0);
        end

        $display("[TB] short debounce, single-cycle pulse");
        for (int e = 1; e <= 8; e++) begin
            applyStimulus(0, 0, 1, 0);
            checkOutput($sformatf("fast_s_e%0d", e), sB, (e == 5));
            checkOutput($sformatf("fast_busy_e%0d", e), busyB, (e == 5 || e == 6));
        end
        repeat (6) applyStimulus(0, 0, 0, 0);

        $display("[TB] random button noise");
        for (int e = 0; e < 300; e++) begin
            applyStimulus(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            checkOutput($sformatf("noise_excl_e%0d", e), sB & rB, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sr_cmd_driver.md
Name: sr_cmd_driver

Overview:
Upstream driver for the SR latch. Two raw, bouncy push-button inputs are synchronised and debounced, then converted into clean, registered, fixed-length set/reset pulses that feed the latch's s and r inputs. The block guarantees that s and r are never asserted together: simultaneous requests are rejected and flagged on a conflict pulse.

Parameters:
DEB_CYCLES, 4, consecutive stable synchronised samples required to accept a level change (2..2^CNT_W-1)
CNT_W, 3, width of each debounce counter
PULSE_LEN, 2, cycles that s or r is held high per accepted command (1..15)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
btn_s  input  1  raw set button, asynchronous to clk
btn_r  input  1  raw reset button, asynchronous to clk
s  output  1  registered set pulse to latch
r  output  1  registered reset pulse to latch
busy  output  1  high while a pulse or guard gap is in progress
conflict  output  1  one-cycle pulse: simultaneous set/reset request rejected

Behaviour:
- Reset is asynchronous and active-high. While reset=1, every flop clears immediately: synchronisers, debounced levels, counters, pending flags and state; s=r=busy=conflict=0, FSM in IDLE. A reset asserted mid-pulse drops s/r within the same cycle. No command is generated on release.
- Synchroniser: 2 flops per button. sync2 is the synchronised value.
- Debounce, per channel: if sync2 == deb, counter clears. Otherwise the counter increments. When the count of consecutive differing samples reaches DEB_CYCLES, deb toggles and the counter clears. A glitch shorter than DEB_CYCLES sampled cycles never changes deb. The counter saturates and never wraps.
- Request = rising edge of deb (deb & ~deb_prev). Falling edges generate nothing.
- Pending flags pend_s/pend_r, one deep each: set by a request while FSM != IDLE, cleared when consumed. A second request on the same channel while pending is dropped.
- Effective request in IDLE: req_x = rise_x | pend_x.
- FSM states: IDLE, DRIVE_S, DRIVE_R, GAP.
  - IDLE:
    - req_s & req_r: stay in IDLE, conflict=1 for one cycle, clear both pendings.
    - Else req_s: go to DRIVE_S. Else req_r: go to DRIVE_R.
  - DRIVE_S / DRIVE_R: s (resp. r) = 1 for exactly PULSE_LEN cycles (pulse counter), then go to GAP.
  - GAP: one cycle with s=r=0, then go to IDLE.
- busy = 1 in DRIVE_S, DRIVE_R and GAP.
- All outputs are registered. s and r are never 1 in the same cycle.
- Latency: btn_s first sampled high at edge 1 and held gives deb=1 after edge DEB_CYCLES+2, and s=1 after edge DEB_CYCLES+3 (edge 7 for the defaults).
- Back-to-back: a command pending from the busy period starts on the edge leaving IDLE. There is a minimum of 1 IDLE cycle plus the GAP between pulses.

Test Plan:
- Reset: assert reset mid-DRIVE_S -> s=r=busy=conflict=0 immediately. After release, no pulse until a new debounced press.
- Clean press: btn_s 0->1 held, defaults -> s=1 after edges 7 and 8 only, r=0 throughout. busy high for 3 cycles (2 drive + 1 gap). Release produces no pulse.
- Bounce: btn_r toggles high 2 cycles, low 1 cycle, repeated 5 times, then held high -> exactly one r pulse of 2 cycles. Each 3-sample glitch (shorter than 4) produces nothing.
- Conflict: btn_s and btn_r rise on the same edge and are held -> conflict=1 for one cycle at edge 7; s and r stay 0; busy stays 0.
- Queued command: btn_r press accepted while DRIVE_S is active -> s pulse (2 cycles), GAP, 1 IDLE cycle, then r pulse (2 cycles). s and r are never overlapping.
- Parameter sweep: DEB_CYCLES=2, PULSE_LEN=1 -> s=1 only after edge 5, single cycle. Repeat with random button noise, checking that s&r==0 holds every cycle.
